// File: rtl/divisor_seq_param_if.sv
// Operand/result bundle between the keypad capture FSM and the sequential divider.
interface divisor_seq_param_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divisor_seq_param.sv
// Restoring divider, one quotient bit per clock; WIDTH+1 edges per result, 1 edge for divide-by-zero.
// No backpressure: start is only accepted in IDLE and ignored while busy.
module divisor_seq_param #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    divisor_seq_param_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state;
    logic [WIDTH-1:0] prem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             neg_r;

    logic             sgn_a;
    logic             sgn_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // The dividend shifts out of quo from the top while quotient bits enter at the bottom.
    always_comb begin
        sgn_a   = SIGNED && bus.dividend[WIDTH-1];
        sgn_b   = SIGNED && bus.divisor[WIDTH-1];
        mag_a   = sgn_a ? -bus.dividend : bus.dividend;
        mag_b   = sgn_b ? -bus.divisor  : bus.divisor;
        shifted = {prem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            prem            <= '0;
            quo             <= '0;
            dvs             <= '0;
            cnt             <= '0;
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            bus.quotient    <= '1;
                            bus.remainder   <= bus.dividend;
                            bus.div_by_zero <= 1'b1;
                            bus.done        <= 1'b1;
                        end else begin
                            quo      <= mag_a;
                            dvs      <= mag_b;
                            prem     <= '0;
                            cnt      <= '0;
                            neg_q    <= sgn_a ^ sgn_b;
                            neg_r    <= sgn_a;
                            bus.busy <= 1'b1;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    // Restored remainder is below the divisor, so its top bit is always zero.
                    if (!trial[WIDTH]) begin
                        prem <= trial[WIDTH-1:0];
                        quo  <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        prem <= shifted[WIDTH-1:0];
                        quo  <= {quo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    bus.quotient    <= neg_q ? -quo  : quo;
                    bus.remainder   <= neg_r ? -prem : prem;
                    bus.div_by_zero <= 1'b0;
                    bus.done        <= 1'b1;
                    bus.busy        <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_divisor_seq_param.sv
// Drives an unsigned and a signed 8-bit divider with identical stimulus and checks both.
module tb_divisor_seq_param;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    divisor_seq_param_if #(.WIDTH(8)) ub ();
    divisor_seq_param_if #(.WIDTH(8)) sb ();

    divisor_seq_param #(.WIDTH(8), .SIGNED(1'b0)) u_dut (.clk(clk), .rst(rst), .bus(ub));
    divisor_seq_param #(.WIDTH(8), .SIGNED(1'b1)) s_dut (.clk(clk), .rst(rst), .bus(sb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] uq;
        logic [7:0] ur;
        logic [7:0] sq;
        logic [7:0] sr;
        bit         z;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [7:0] a, input logic [7:0] b);
        ub.start = s; ub.dividend = a; ub.divisor = b;
        sb.start = s; sb.dividend = a; sb.divisor = b;
    endtask

    // Reference: plain integer division, truncation toward zero.
    task automatic model(input logic [7:0] a, input logic [7:0] b, input bit sgn,
                         output logic [7:0] q, output logic [7:0] r, output bit z);
        int sa, sbv, qi, ri;
        z = (b == 8'd0);
        if (z) begin
            q = 8'hFF; r = a;
        end else begin
            sa  = sgn ? int'($signed(a)) : int'(a);
            sbv = sgn ? int'($signed(b)) : int'(b);
            qi  = sa / sbv;
            ri  = sa % sbv;
            q = qi[7:0]; r = ri[7:0];
        end
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_ubusy"}, int'(ub.busy), 0);
        chk({nm, "_udone"}, int'(ub.done), 0);
        chk({nm, "_uq"}, int'(ub.quotient), 0);
        chk({nm, "_ur"}, int'(ub.remainder), 0);
        chk({nm, "_uz"}, int'(ub.div_by_zero), 0);
        chk({nm, "_sbusy"}, int'(sb.busy), 0);
        chk({nm, "_sdone"}, int'(sb.done), 0);
        chk({nm, "_sq"}, int'(sb.quotient), 0);
        chk({nm, "_sr"}, int'(sb.remainder), 0);
        chk({nm, "_sz"}, int'(sb.div_by_zero), 0);
    endtask

    task automatic apply(input string nm, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] uq, input logic [7:0] ur,
                         input logic [7:0] sq, input logic [7:0] sr, input bit z);
        int ude, sde, ubc, sbc;
        @(negedge clk);
        drive(1'b1, a, b);
        ude = -1; sde = -1; ubc = 0; sbc = 0;
        for (int e = 0; e < 20 && (ude < 0 || sde < 0); e++) begin
            @(posedge clk); #1;
            if (e == 0) drive(1'b0, a, b);
            if (ub.busy) ubc++;
            if (sb.busy) sbc++;
            if (ub.done && ude < 0) ude = e;
            if (sb.done && sde < 0) sde = e;
        end
        chk({nm, "_uedge"}, ude, z ? 0 : 9);
        chk({nm, "_sedge"}, sde, z ? 0 : 9);
        chk({nm, "_ubusy"}, ubc, z ? 0 : 9);
        chk({nm, "_sbusy"}, sbc, z ? 0 : 9);
        chk({nm, "_uq"}, int'(ub.quotient), int'(uq));
        chk({nm, "_ur"}, int'(ub.remainder), int'(ur));
        chk({nm, "_uz"}, int'(ub.div_by_zero), int'(z));
        chk({nm, "_sq"}, int'(sb.quotient), int'(sq));
        chk({nm, "_sr"}, int'(sb.remainder), int'(sr));
        chk({nm, "_sz"}, int'(sb.div_by_zero), int'(z));
        @(posedge clk); #1;
        chk({nm, "_udrop"}, int'(ub.done), 0);
        chk({nm, "_sdrop"}, int'(sb.done), 0);
    endtask

    initial begin
        vec_t       vecs[$];
        logic [7:0] a, b, uq, ur, sq, sr;
        bit         z, zs;
        int         dones[$];
        int         ndone;

        checks = 0;
        errors = 0;
        rst = 1'b0;
        drive(1'b0, 8'd0, 8'd0);

        vecs.push_back('{"u69_7",    8'd69,  8'd7,   8'd9,   8'd6,   8'd9,   8'd6,   1'b0});
        vecs.push_back('{"u255_1",   8'd255, 8'd1,   8'd255, 8'd0,   8'hFF,  8'd0,   1'b0});
        vecs.push_back('{"u3_10",    8'd3,   8'd10,  8'd0,   8'd3,   8'd0,   8'd3,   1'b0});
        vecs.push_back('{"u0_5",     8'd0,   8'd5,   8'd0,   8'd0,   8'd0,   8'd0,   1'b0});
        vecs.push_back('{"dbz5_0",   8'd5,   8'd0,   8'hFF,  8'd5,   8'hFF,  8'd5,   1'b1});
        vecs.push_back('{"u8_2",     8'd8,   8'd2,   8'd4,   8'd0,   8'd4,   8'd0,   1'b0});
        vecs.push_back('{"sn69_7",   8'hBB,  8'd7,   8'd26,  8'd5,   8'hF7,  8'hFA,  1'b0});
        vecs.push_back('{"s69_n7",   8'd69,  8'hF9,  8'd0,   8'd69,  8'hF7,  8'd6,   1'b0});
        vecs.push_back('{"sovf",     8'h80,  8'hFF,  8'd0,   8'h80,  8'h80,  8'd0,   1'b0});

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i])
            apply(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].uq, vecs[i].ur,
                  vecs[i].sq, vecs[i].sr, vecs[i].z);

        // New start with different operands at edge 4 must be ignored.
        @(negedge clk);
        drive(1'b1, 8'd69, 8'd7);
        ndone = 0; dones.delete();
        for (int e = 0; e < 20; e++) begin
            @(posedge clk); #1;
            if (e == 0) drive(1'b0, 8'd69, 8'd7);
            if (e == 3) drive(1'b1, 8'd200, 8'd3);
            if (e == 4) drive(1'b0, 8'd200, 8'd3);
            if (ub.done) begin
                ndone++;
                dones.push_back(e);
                chk("abuse_uq", int'(ub.quotient), 9);
                chk("abuse_ur", int'(ub.remainder), 6);
                chk("abuse_sq", int'(sb.quotient), 9);
            end
        end
        chk("abuse_ndone", ndone, 1);
        chk("abuse_edge", (dones.size() > 0) ? dones[0] : -1, 9);

        // Start held high: one result every 10 cycles.
        @(negedge clk);
        drive(1'b1, 8'd69, 8'd7);
        dones.delete();
        for (int e = 0; e < 45; e++) begin
            @(posedge clk); #1;
            if (ub.done) dones.push_back(e);
        end
        drive(1'b0, 8'd69, 8'd7);
        chk("b2b_count", dones.size(), 4);
        chk("b2b_first", (dones.size() > 0) ? dones[0] : -1, 9);
        for (int i = 1; i < dones.size(); i++)
            chk("b2b_period", dones[i] - dones[i-1], 10);
        repeat (12) @(posedge clk);

        // Reset mid-division discards the operation.
        @(negedge clk);
        drive(1'b1, 8'd50, 8'd3);
        for (int e = 0; e < 6; e++) begin
            @(posedge clk); #1;
            if (e == 0) drive(1'b0, 8'd50, 8'd3);
            if (e == 4) rst = 1'b0;
        end
        check_zero("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        for (int e = 0; e < 15; e++) begin
            @(posedge clk); #1;
            if (ub.done || sb.done) ndone++;
        end
        chk("midrst_nodone", ndone, 0);
        apply("post_rst_100_9", 8'd100, 8'd9, 8'd11, 8'd1, 8'd11, 8'd1, 1'b0);

        // Random operands against the arithmetic reference.
        for (int i = 0; i < 150; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            model(a, b, 1'b0, uq, ur, z);
            model(a, b, 1'b1, sq, sr, zs);
            apply("rand", a, b, uq, ur, sq, sr, z);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/divisor_seq_param.md
# divisor_seq_param

Parametrised sequential restoring divider with a start/done handshake, optional two's-complement mode and divide-by-zero detection. It replaces the fixed 8-bit divider in the keypad/seven-segment calculator path. The keypad-capture FSM drives operands and `start`; the display logic consumes `quotient`/`remainder` on `done`. Computes one quotient bit per clock, so a WIDTH-bit division completes in WIDTH+1 clock edges.

## Interface
- `WIDTH`, default 8: operand, quotient and remainder width in bits; legal range 2..32.
- `SIGNED`, default 0: 0 selects unsigned division; 1 selects two's-complement division.
- `clk` input 1: single clock, rising-edge active.
- `rst` input 1: reset, synchronous, active-low. It has priority over every other input.
- `start` input 1: request. Sampled only in IDLE.
- `dividend` input WIDTH: sampled at the edge where `start` is accepted.
- `divisor` input WIDTH: sampled at the edge where `start` is accepted.
- `busy` output 1: high while a division is in flight.
- `done` output 1: one-cycle pulse marking that the results just updated.
- `quotient` output WIDTH: result. Held until the next completion.
- `remainder` output WIDTH: result. Held until the next completion.
- `div_by_zero` output 1: error flag for the last completed operation. Held with the results.

## Operation
- FSM states: IDLE, CALC, FIX.
- IDLE, `start`=1, divisor≠0:
  - Latch operands. In SIGNED mode, latch their magnitudes plus both sign bits.
  - Clear the partial remainder (WIDTH+1 bits) and the iteration counter (clog2(WIDTH+1) bits).
  - Set `busy`. Go to CALC.
- IDLE, `start`=1, divisor=0:
  - Go directly to the completion write: `quotient`=all ones, `remainder`=dividend (raw bits), `div_by_zero`=1, `done`=1.
  - Stay in IDLE. `busy` never rises.
- CALC, one iteration per edge, WIDTH iterations total:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor magnitude.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - After iteration WIDTH, go to FIX.
- FIX:
  - In SIGNED mode, negate the quotient if the operand signs differ. Negate the remainder if the dividend is negative, so the remainder sign follows the dividend and the quotient truncates toward zero.
  - Write `quotient`, `remainder`, and `div_by_zero`=0. Pulse `done`. Clear `busy`. Go to IDLE.
- Signed overflow: most-negative ÷ −1 gives `quotient`=most-negative (wraps), `remainder`=0, `div_by_zero`=0.
- Unsigned mode ignores sign handling entirely. FIX then only writes the results.
- `start` while `busy`=1 is ignored. It is not queued, and operand changes during CALC have no effect.
- `dividend` < `divisor` (unsigned): `quotient`=0, `remainder`=dividend.

## Timing
- Reset (`rst`=0 at a rising edge):
  - State IDLE; `busy`, `done`, `div_by_zero` = 0; `quotient`, `remainder` = 0.
  - Any in-flight division is discarded and produces no `done`.
- Normal division, counting `start` accepted at edge 0:
  - `busy`=1 after edges 0..WIDTH and =0 after edge WIDTH+1.
  - Results and `done`=1 appear after edge WIDTH+1. `done` falls after edge WIDTH+2.
  - Latency is WIDTH+1 edges (9 for WIDTH=8).
- Divide-by-zero: results and `done` appear after edge 0 itself; latency 1 edge.
- Back-to-back operation:
  - A `start` held high through completion is accepted at edge WIDTH+2, the first edge seen in IDLE.
  - Throughput is one division per WIDTH+2 cycles.
- `start` and `rst`=0 at the same edge: reset wins and `start` is lost.
- Outputs are registered only; there is no combinational path from inputs to outputs.

## Test plan
- Unsigned, WIDTH=8, 69÷7:
  - `start` at edge 0 → `done` after edge 9 only.
  - `quotient`=9, `remainder`=6, `div_by_zero`=0.
  - `busy` high for exactly 9 cycles.
- Unsigned edge values:
  - 255÷1 → Q=255, R=0.
  - 3÷10 → Q=0, R=3.
  - 0÷5 → Q=0, R=0.
- Divide-by-zero: 5÷0 → `done` after edge 0, Q=0xFF, R=5, `div_by_zero`=1, `busy` never high. A following 8÷2 clears the flag and gives Q=4, R=0.
- SIGNED=1, WIDTH=8:
  - −69÷7 → Q=0xF7 (−9), R=0xFA (−6).
  - 69÷−7 → Q=0xF7, R=6.
  - −128÷−1 → Q=0x80, R=0.
- Handshake abuse:
  - Pulse `start` with new operands at edge 4 of a 69÷7 run → ignored, results still 9/6, exactly one `done`.
  - Hold `start` high continuously → `done` pulses every 10 cycles.
- Reset mid-operation:
  - `rst`=0 at edge 5 of a division → all outputs 0 after that edge, no `done`.
  - After release, a new 100÷9 gives Q=11, R=1 with latency 9.
